// File: rtl/lotr_pkg.sv
// rtl/lotr_pkg.sv - shared lotr constants and boot FSM state type (LOTR_BOOT_CHECKSUM_EN adds CHECK/ERROR)
package lotr_pkg;

  localparam int LOTR_NUM_CORES   = 4;
  localparam int LOTR_IMEM_ADDR_W = 10;

  typedef enum logic [2:0] {
    STRETCH = 3'd0,
    LOAD    = 3'd1,
`ifdef LOTR_BOOT_CHECKSUM_EN
    CHECK   = 3'd2,
    ERROR   = 3'd5,
`endif
    RELEASE = 3'd3,
    DONE    = 3'd4
  } t_boot_state;

endpackage

// File: rtl/lotr_boot_ctrl_if.sv
// rtl/lotr_boot_ctrl_if.sv - boot stream, I-mem write port and core reset bundle
interface lotr_boot_ctrl_if
  import lotr_pkg::*;
#(
  parameter int NUM_CORES = LOTR_NUM_CORES,
  parameter int ADDR_W    = LOTR_IMEM_ADDR_W
);

  logic                 BootValid;
  logic [31:0]          BootData;
  logic                 BootReady;
  logic                 ImemWrEn;
  logic [ADDR_W-1:0]    ImemWrAddr;
  logic [31:0]          ImemWrData;
  logic [NUM_CORES-1:0] CoreRstQnnnH;
  logic                 BootDone;
  logic                 BootErr;

  // Environment side: supplies the boot image, observes I-mem writes and core resets.
  modport master (
    output BootValid, BootData,
    input  BootReady, ImemWrEn, ImemWrAddr, ImemWrData, CoreRstQnnnH, BootDone, BootErr
  );

  // Boot controller side.
  modport slave (
    input  BootValid, BootData,
    output BootReady, ImemWrEn, ImemWrAddr, ImemWrData, CoreRstQnnnH, BootDone, BootErr
  );

endinterface

// File: rtl/lotr_rst_stagger.sv
// rtl/lotr_rst_stagger.sv - staggered per-core reset release after a start pulse
module lotr_rst_stagger #(
  parameter int NUM_CORES    = 4,
  parameter int CORE_STAGGER = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic [NUM_CORES-1:0] core_rst_o,
  output logic                 all_rel_o
);

  localparam int IDX_W = $clog2(NUM_CORES + 1);
  localparam int CNT_W = (CORE_STAGGER > 1) ? $clog2(CORE_STAGGER) : 1;

  logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 run_q, run_d;

  // Core 0 drops on the start edge; each following core drops CORE_STAGGER edges after the previous one.
  always_comb begin
    core_rst_d = core_rst_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    all_rel_o  = 1'b0;
    if (start_i) begin
      core_rst_d[0] = 1'b0;
      idx_d         = IDX_W'(1);
      cnt_d         = '0;
      run_d         = 1'b1;
    end else if (run_q) begin
      if (idx_q == IDX_W'(NUM_CORES)) begin
        all_rel_o = 1'b1;
        run_d     = 1'b0;
      end else if (cnt_q == CNT_W'(CORE_STAGGER - 1)) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (idx_q == IDX_W'(i)) core_rst_d[i] = 1'b0;
        end
        idx_d = idx_q + 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Release state registers; reset re-holds every core.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_rst_q <= '1;
      idx_q      <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
    end else begin
      core_rst_q <= core_rst_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
    end
  end

  assign core_rst_o = core_rst_q;

endmodule

// File: rtl/lotr_boot_ctrl.sv
// rtl/lotr_boot_ctrl.sv - boot sequencer: reset stretch, image load, staggered release (LOTR_BOOT_CHECKSUM_EN enables checksum check)
module lotr_boot_ctrl
  import lotr_pkg::*;
#(
  parameter int NUM_CORES    = LOTR_NUM_CORES,
  parameter int IMG_WORDS    = 256,
  parameter int ADDR_W       = LOTR_IMEM_ADDR_W,
  parameter int RST_STRETCH  = 16,
  parameter int CORE_STAGGER = 8
) (
  input  logic              QClk,
  input  logic              RstQnnnH,
  lotr_boot_ctrl_if.slave   bus
);

  localparam int SW = $clog2(RST_STRETCH + 1);

  t_boot_state          state_q, state_d;
  logic [SW-1:0]        str_cnt_q, str_cnt_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 xfer;
  logic                 start_rel;
  logic                 all_rel;
  logic [NUM_CORES-1:0] core_rst;
`ifdef LOTR_BOOT_CHECKSUM_EN
  logic [31:0]          sum_q, sum_d;
  logic                 err_q, err_d;
`endif

  // Next-state, address/data capture and registered ready/status decode.
  always_comb begin
    state_d   = state_q;
    str_cnt_d = str_cnt_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LOTR_BOOT_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    xfer      = bus.BootValid && ready_q;
    case (state_q)
      STRETCH: begin
        if (str_cnt_q == SW'(RST_STRETCH)) state_d = LOAD;
        else                                str_cnt_d = str_cnt_q + 1'b1;
      end
      LOAD: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = bus.BootData;
          idx_d     = idx_q + 1'b1;
`ifdef LOTR_BOOT_CHECKSUM_EN
          sum_d     = sum_q + bus.BootData;
          if (idx_q == ADDR_W'(IMG_WORDS - 1)) state_d = CHECK;
`else
          if (idx_q == ADDR_W'(IMG_WORDS - 1)) state_d = RELEASE;
`endif
        end
      end
`ifdef LOTR_BOOT_CHECKSUM_EN
      CHECK: begin
        if (xfer) state_d = (bus.BootData == sum_q) ? RELEASE : ERROR;
      end
`endif
      RELEASE: begin
        if (all_rel) state_d = DONE;
      end
      default: ;
    endcase
    start_rel = (state_q != RELEASE) && (state_d == RELEASE);
`ifdef LOTR_BOOT_CHECKSUM_EN
    ready_d   = (state_d == LOAD) || (state_d == CHECK);
    err_d     = (state_d == ERROR);
`else
    ready_d   = (state_d == LOAD);
`endif
    done_d    = (state_d == DONE);
  end

  // State and output registers; reset discards any partial image.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      state_q   <= STRETCH;
      str_cnt_q <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef LOTR_BOOT_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      str_cnt_q <= str_cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef LOTR_BOOT_CHECKSUM_EN
      sum_q     <= sum_d;
      err_q     <= err_d;
`endif
    end
  end

  lotr_rst_stagger #(
    .NUM_CORES    (NUM_CORES),
    .CORE_STAGGER (CORE_STAGGER)
  ) u_stagger (
    .clk_i      (QClk),
    .rst_i      (RstQnnnH),
    .start_i    (start_rel),
    .core_rst_o (core_rst),
    .all_rel_o  (all_rel)
  );

  assign bus.BootReady    = ready_q;
  assign bus.ImemWrEn     = wr_en_q;
  assign bus.ImemWrAddr   = wr_addr_q;
  assign bus.ImemWrData   = wr_data_q;
  assign bus.CoreRstQnnnH = core_rst;
  assign bus.BootDone     = done_q;
`ifdef LOTR_BOOT_CHECKSUM_EN
  assign bus.BootErr      = err_q;
`else
  assign bus.BootErr      = 1'b0;
`endif

endmodule

// File: tb/tb_lotr_boot_ctrl.sv
// tb/tb_lotr_boot_ctrl.sv - randomized self-checking bench for lotr_boot_ctrl
module tb_lotr_boot_ctrl;
  import lotr_pkg::*;

  localparam int NC = 4;
  localparam int IW = 4;
  localparam int AW = 10;
  localparam int RS = 16;
  localparam int CS = 8;
`ifdef LOTR_BOOT_CHECKSUM_EN
  localparam int TOTAL = IW + 1;
`else
  localparam int TOTAL = IW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  lotr_boot_ctrl_if #(.NUM_CORES(NC), .ADDR_W(AW)) bus ();

  lotr_boot_ctrl #(
    .NUM_CORES    (NC),
    .IMG_WORDS    (IW),
    .ADDR_W       (AW),
    .RST_STRETCH  (RS),
    .CORE_STAGGER (CS)
  ) dut (
    .QClk     (clk),
    .RstQnnnH (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string ctx);
    check({ctx, ".ready"}, 32'(bus.BootReady), 32'd0);
    check({ctx, ".wr_en"}, 32'(bus.ImemWrEn), 32'd0);
    check({ctx, ".addr"}, 32'(bus.ImemWrAddr), 32'd0);
    check({ctx, ".data"}, bus.ImemWrData, 32'd0);
    check({ctx, ".core_rst"}, 32'(bus.CoreRstQnnnH), 32'((1 << NC) - 1));
    check({ctx, ".done"}, 32'(bus.BootDone), 32'd0);
    check({ctx, ".err"}, 32'(bus.BootErr), 32'd0);
  endtask

  // vmode: 0 back-to-back, 1 alternate, 2 random; dmode: 0 directed 0x11..0x44, 1 random
  // rmode: 0 none, 1 reset after 2 words accepted, 2 reset after cores 0-1 released
  task automatic run_scen(input int vmode, input int dmode, input bit bad_ck, input int rmode);
    int k, acc, last_e;
    logic [31:0] sum, d;
    bit err, exp_rdy, v, xfer, ewr, fired, finished, exp_done;
    logic [AW-1:0] ewa;
    logic [31:0] ewd;
    logic [NC-1:0] ecr;

    rst = 1'b1;
    bus.BootValid = 1'b0;
    bus.BootData  = '0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset_vals("reset");
    end
    rst = 1'b0;
    k = 0; acc = 0; last_e = -1; sum = '0; err = 1'b0; exp_rdy = 1'b0;
    fired = 1'b0; finished = 1'b0;

    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      if (!fired && ((rmode == 1 && acc == 2) ||
                     (rmode == 2 && last_e >= 0 && !err && k == last_e + CS + 1))) begin
        fired = 1'b1;
        rst = 1'b1;
        bus.BootValid = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midreset");
        rst = 1'b0;
        k = 0; acc = 0; last_e = -1; sum = '0; err = 1'b0; exp_rdy = 1'b0;
      end

      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (!v)              d = $urandom();
      else if (acc < IW)   d = (dmode == 0) ? 32'(32'h11 * (acc + 1)) : $urandom();
      else                 d = bad_ck ? sum + 32'd1 : sum;
      bus.BootValid = v;
      bus.BootData  = d;

      @(posedge clk);
      xfer = v && exp_rdy;
      ewr  = 1'b0;
      ewa  = '0;
      ewd  = '0;
      if (xfer) begin
        if (acc < IW) begin
          ewr = 1'b1;
          ewa = AW'(acc);
          ewd = d;
          sum = sum + d;
          acc++;
          if (acc == TOTAL) last_e = k;
        end else begin
          acc++;
          last_e = k;
          err = (d != sum);
        end
      end
      exp_rdy = (k >= RS) && (acc < TOTAL);
      ecr = '1;
      for (int i = 0; i < NC; i++) begin
        if (last_e >= 0 && !err && k >= last_e + i * CS) ecr[i] = 1'b0;
      end
      exp_done = (last_e >= 0) && !err && (k >= last_e + (NC - 1) * CS + 1);

      #1;
      check("ready", 32'(bus.BootReady), 32'(exp_rdy));
      check("wr_en", 32'(bus.ImemWrEn), 32'(ewr));
      if (ewr) begin
        check("wr_addr", 32'(bus.ImemWrAddr), 32'(ewa));
        check("wr_data", bus.ImemWrData, ewd);
      end
      check("core_rst", 32'(bus.CoreRstQnnnH), 32'(ecr));
      check("done", 32'(bus.BootDone), 32'(exp_done));
      check("err", 32'(bus.BootErr), 32'(err));

      if (last_e >= 0 && (fired || rmode == 0) &&
          ((err && k > last_e + 4) || (!err && k > last_e + (NC - 1) * CS + 4)))
        finished = 1'b1;
      k++;
    end
    check("scenario_end", 32'(finished), 32'd1);
    bus.BootValid = 1'b0;
  endtask

  initial begin
    bus.BootValid = 1'b0;
    bus.BootData  = '0;
    run_scen(0, 0, 1'b0, 0);
    run_scen(1, 0, 1'b0, 0);
    run_scen(0, 0, 1'b0, 1);
    run_scen(2, 1, 1'b0, 2);
    run_scen(2, 1, 1'b0, 1);
    for (int n = 0; n < 4; n++) run_scen(2, 1, 1'b0, 0);
`ifdef LOTR_BOOT_CHECKSUM_EN
    run_scen(0, 0, 1'b1, 0);
    run_scen(2, 1, 1'b1, 0);
    run_scen(1, 1, 1'b1, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
